// File: rtl/gen_elastic_reg.sv
// gen_elastic_reg: DEPTH-entry circular elastic buffer with valid/ready on both
// sides. It sits between pipeline stages and absorbs back-pressure.
// out_data comes straight from storage, so there is never a combinational path
// from in_data to out_data. in_ready depends only on the occupancy count.
// Optional build macro: GEN_ELASTIC_PARITY_EN. When it is defined, each entry
// keeps an even-parity bit and par_err flags a corrupted head word. The port
// list is the same in both builds.
module gen_elastic_reg #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count,
  output logic             par_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push, pop;

  // Pointers walk 0..DEPTH-1, so DEPTH does not have to be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (cnt != CNT_W'(DEPTH));
  assign out_valid = (cnt != '0);
  assign count     = cnt;
  assign out_data  = mem[rd_ptr];

  // A flush overrides both handshakes, so a word that arrives during a flush is dropped.
  assign push = in_valid  & in_ready  & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // Storage array. It is cleared on reset so that out_data reads 0 while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointer and occupancy bookkeeping. A flush returns everything to the empty state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef GEN_ELASTIC_PARITY_EN
  logic mem_par [DEPTH];

  // Even-parity bit that is computed when the word is pushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_par[i] <= 1'b0;
    end else if (push) begin
      mem_par[wr_ptr] <= ^in_data;
    end
  end

  assign par_err = out_valid & (^{mem[rd_ptr], mem_par[rd_ptr]});
`else
  assign par_err = 1'b0;
`endif

endmodule
